alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Sequential controller for the three-sensor alarm function, with sensors A, B and C. It synchronizes the sensor inputs and evaluates the 2-of-3 alarm equation. It also sequences arming, exit delay, entry delay and a timed siren, and counts alarm events. It sits between the raw sensor pins and the siren/LED outputs of the alarm board.

## Interface
- `EXIT_CYCLES`, default 8: cycles spent in exit delay after arming.
- `ENTRY_CYCLES`, default 4: cycles of grace between a qualified trigger and the siren.
- `SIREN_CYCLES`, default 16: cycles the siren stays on per alarm.
- `CNT_W`, default 8: width of the delay counter; must hold max(EXIT, ENTRY, SIREN) − 1.

Ports:
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sens_a`, `sens_b`, `sens_c`, in, 1 each: raw sensor levels, asynchronous to `clk`.
- `arm`, in, 1: level-sampled arm request.
- `disarm`, in, 1: level-sampled disarm request.
- `siren`, out, 1: registered siren drive.
- `armed`, out, 1: registered; high in EXIT, ARMED, ENTRY and ALARM.
- `state_o`, out, 3: current state encoding.
- `alarm_cnt`, out, 8: count of ALARM entries, saturating at 255.

## Operation
- Sensors pass through a 2-flop synchronizer per bit, then through `alarm_eval`: trig = AB | AC | BC.
- States and encodings: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. Encodings 5–7 go to DISARMED on the next edge.
- In every state, `disarm`=1 moves to DISARMED with cnt=0. Disarm beats arm and trig in the same cycle.
- DISARMED: `arm`=1 → EXIT, cnt ← EXIT_CYCLES−1. trig is ignored.
- EXIT: decrement cnt; at cnt=0 → ARMED. trig is ignored.
- ARMED: qualified trig=1 → ENTRY, cnt ← ENTRY_CYCLES−1. `arm` is ignored.
- ENTRY: decrement cnt; at cnt=0 → ALARM, cnt ← SIREN_CYCLES−1, and alarm_cnt increments unless it is 255. trig deasserting does not cancel entry.
- ALARM: decrement cnt; at cnt=0 → ARMED (auto re-arm). If trig is still high, the next cycle goes to ENTRY again.
- Outputs: `siren` = (state==ALARM); `armed` = (state≠DISARMED); `state_o` = state. All are registered and have no combinational path from inputs.

## Timing
- Reset values: sync flops 0, state DISARMED, cnt 0, siren 0, armed 0, state_o 0, alarm_cnt 0.
- Sensor to trig: 2 cycles (synchronizer). trig to ENTRY: 1 further edge. Total 3 edges without debounce.
- ENTRY lasts exactly ENTRY_CYCLES cycles and ALARM lasts exactly SIREN_CYCLES cycles. EXIT lasts EXIT_CYCLES cycles.
- arm/disarm act on the first edge at which they are sampled high and are not synchronized. Callers provide signals synchronous to `clk`.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Deassertion is expected synchronous to `clk`.
- alarm_cnt has no clear except reset.

## Configuration
- `ALARM_CTRL_DEBOUNCE_EN` defined: trig qualifies only after being 1 on 3 consecutive cycles after the synchronizer, using a 2-bit run counter that clears on any 0. Sensor-to-ENTRY latency is then 5 edges.
- Undefined: the synchronized trig qualifies directly, and no debounce logic is synthesized.

## Structure
- Shared package `alarm_pkg`: the state typedef/localparams (the five encodings), the width constant for alarm_cnt (8), and the debounce run length (3).
- Sub-module `alarm_eval`: combinational majority of a, b, c. It is instantiated once after the synchronizer.
- The synchronizer, optional debounce, FSM, delay counter and event counter live in `alarm_ctrl`.

## Test plan
- Reset with all inputs 0 → siren=0, armed=0, state_o=0, alarm_cnt=0. Sensors A=B=1 while disarmed → state stays 0.
- Pulse arm 1 cycle → state_o=1 for 8 cycles, then 2. A=B=1 during EXIT → no transition.
- From ARMED, set A=1, C=1 and hold: ENTRY after 3 edges (5 with debounce), then siren=1 for exactly 16 cycles, then state_o=2 → ENTRY again. alarm_cnt=1 after the first alarm.
- From ARMED, apply a single-sensor trigger (B=1 only) → no transition. Without debounce, a 1-cycle A=B=1 glitch → ENTRY; with debounce → no transition.
- In ENTRY at cnt=2, assert disarm and arm together → DISARMED next edge, siren never asserts, alarm_cnt unchanged.
- Force 256 alarm cycles → alarm_cnt holds 255. Assert rst_n=0 mid-ALARM → siren=0 and state_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the three-sensor alarm controller: state encodings,
// event-counter width and debounce run length.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_e;

  localparam int ALARM_CNT_W  = 8;
  localparam int DEBOUNCE_RUN = 3;

endpackage

// File: rtl/alarm_eval.sv
// 2-of-3 majority vote over the synchronized sensor levels.
module alarm_eval (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic trig
);

  assign trig = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: sensor synchronizer, majority trigger, arm/exit/entry/siren FSM
// and saturating alarm counter. Define ALARM_CTRL_DEBOUNCE_EN to require a 3-cycle trigger run.
//
// state     | meaning
// DISARMED  | idle, sensors ignored, waiting for arm
// EXIT      | exit delay after arming, sensors ignored
// ARMED     | watching for a qualified trigger
// ENTRY     | grace period before the siren
// ALARM     | siren on for SIREN_CYCLES, then re-arm
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int EXIT_CYCLES  = 8,
  parameter int ENTRY_CYCLES = 4,
  parameter int SIREN_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sens_a,
  input  logic                   sens_b,
  input  logic                   sens_c,
  input  logic                   arm,
  input  logic                   disarm,
  output logic                   siren,
  output logic                   armed,
  output logic [2:0]             state_o,
  output logic [ALARM_CNT_W-1:0] alarm_cnt
);

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

  logic [2:0]             sync1_q, sync2_q;
  logic                   trig, trig_qual;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic                   siren_q, armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sens_c, sens_b, sens_a};
      sync2_q <= sync1_q;
    end
  end

  alarm_eval u_eval (
    .a    (sync2_q[0]),
    .b    (sync2_q[1]),
    .c    (sync2_q[2]),
    .trig (trig)
  );

`ifdef ALARM_CTRL_DEBOUNCE_EN
  localparam logic [1:0] RUN_MAX = 2'(DEBOUNCE_RUN - 1);
  logic [1:0] run_q;

  // run_q saturates once the trigger has been high on the two previous cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               run_q <= '0;
    else if (!trig)           run_q <= '0;
    else if (run_q != RUN_MAX) run_q <= run_q + 2'd1;
  end

  assign trig_qual = trig && (run_q == RUN_MAX);
`else
  assign trig_qual = trig;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alarm_cnt_d = alarm_cnt_q;
    if (disarm) begin
      state_d = ST_DISARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            state_d = ST_EXIT;
            cnt_d   = EXIT_LOAD;
          end
        end
        ST_EXIT: begin
          if (cnt_q == '0) state_d = ST_ARMED;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_ARMED: begin
          if (trig_qual) begin
            state_d = ST_ENTRY;
            cnt_d   = ENTRY_LOAD;
          end
        end
        ST_ENTRY: begin
          if (cnt_q == '0) begin
            state_d = ST_ALARM;
            cnt_d   = SIREN_LOAD;
            if (alarm_cnt_q != '1) alarm_cnt_d = alarm_cnt_q + ALARM_CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_ALARM: begin
          if (cnt_q == '0) state_d = ST_ARMED;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = ST_DISARMED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // siren/armed are registered from the next state so they line up with state_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DISARMED;
      cnt_q       <= '0;
      alarm_cnt_q <= '0;
      siren_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      siren_q     <= (state_d == ST_ALARM);
      armed_q     <= (state_d != ST_DISARMED);
    end
  end

  assign siren     = siren_q;
  assign armed     = armed_q;
  assign state_o   = state_q;
  assign alarm_cnt = alarm_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a timeline reference model predicts outputs
// every edge; a negedge monitor compares; directed steps probe latency and limits.
module tb_alarm_ctrl;

  localparam int EXIT_N  = 8;
  localparam int ENTRY_N = 4;
  localparam int SIREN_N = 16;
`ifdef ALARM_CTRL_DEBOUNCE_EN
  localparam int QUAL_RUN = 3;
`else
  localparam int QUAL_RUN = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sa = 1'b0, sb = 1'b0, sc = 1'b0;
  logic       arm = 1'b0, disarm = 1'b0;
  logic       siren, armed;
  logic [2:0] state_o;
  logic [7:0] alarm_cnt;

  alarm_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sens_a    (sa),
    .sens_b    (sb),
    .sens_c    (sc),
    .arm       (arm),
    .disarm    (disarm),
    .siren     (siren),
    .armed     (armed),
    .state_o   (state_o),
    .alarm_cnt (alarm_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       sir;
    logic       arm;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: phase number plus cycles left in the phase
  int   m_phase, m_left, m_alarms, m_streak, m_votes;
  bit   m_qual;
  bit [2:0] m_s1, m_s2;
  exp_t m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_alarms = 0; m_streak = 0;
      m_s1 = '0; m_s2 = '0;
    end else begin
      m_votes  = int'(m_s2[0]) + int'(m_s2[1]) + int'(m_s2[2]);
      m_streak = (m_votes >= 2) ? m_streak + 1 : 0;
      m_qual   = (m_streak >= QUAL_RUN);
      m_s2 = m_s1;
      m_s1 = {sc, sb, sa};
      if (disarm) begin
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (arm) begin m_phase = 1; m_left = EXIT_N; end
          1: begin m_left--; if (m_left == 0) m_phase = 2; end
          2: if (m_qual) begin m_phase = 3; m_left = ENTRY_N; end
          3: begin
            m_left--;
            if (m_left == 0) begin
              m_phase = 4; m_left = SIREN_N;
              if (m_alarms < 255) m_alarms++;
            end
          end
          4: begin m_left--; if (m_left == 0) m_phase = 2; end
          default: m_phase = 0;
        endcase
      end
      m_exp.st  = 3'(m_phase);
      m_exp.sir = (m_phase == 4);
      m_exp.arm = (m_phase != 0);
      m_exp.cnt = 8'(m_alarms);
      sb_q.push_back(m_exp);
    end
  end

  exp_t mon_exp, mon_got;
  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_got.st  = state_o;
      mon_got.sir = siren;
      mon_got.arm = armed;
      mon_got.cnt = alarm_cnt;
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL scoreboard t=%0t got st=%0d siren=%0b armed=%0b cnt=%0d exp st=%0d siren=%0b armed=%0b cnt=%0d",
                 $time, mon_got.st, mon_got.sir, mon_got.arm, mon_got.cnt,
                 mon_exp.st, mon_exp.sir, mon_exp.arm, mon_exp.cnt);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_state(input int target, input int budget, input string name);
    int n = 0;
    while (state_o !== 3'(target) && n < budget) begin step(1); n++; end
    check(name, int'(state_o), target);
  endtask

  task automatic set_sens(input logic a, input logic b, input logic c);
    sa = a; sb = b; sc = c;
  endtask

  int n, saved;
  logic [2:0] rbits;

  initial begin
    // reset state
    #7;
    check("rst_siren", int'(siren), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_state", int'(state_o), 0);
    check("rst_cnt", int'(alarm_cnt), 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // majority while disarmed is ignored
    set_sens(1, 1, 0);
    step(6);
    check("disarmed_ignore", int'(state_o), 0);
    set_sens(0, 0, 0);
    step(3);

    // arm pulse, sensors during exit ignored
    arm = 1'b1; step(1); arm = 1'b0;
    check("exit_enter", int'(state_o), 1);
    step(1);
    set_sens(1, 1, 0); step(3); set_sens(0, 0, 0);
    wait_state(2, 20, "exit_to_armed");
    step(4);

    // held A+C: trigger latency, siren length, re-entry
    set_sens(1, 0, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (state_o !== 3'd3 && n < 20);
    check("trig_latency", n, QUAL_RUN == 3 ? 5 : 3);
    #1;
    n = 0;
    while (!siren && n < 20) begin step(1); n++; end
    check("siren_rise", int'(siren), 1);
    n = 0;
    while (siren && n < 50) begin n++; step(1); end
    check("siren_len", n, SIREN_N);
    check("rearm_state", int'(state_o), 2);
    check("first_alarm_cnt", int'(alarm_cnt), 1);
    step(1);
    check("reentry", int'(state_o), 3);
    disarm = 1'b1; step(1); disarm = 1'b0;
    set_sens(0, 0, 0);
    check("disarm", int'(state_o), 0);
    step(3);

    // single sensor, then 1-cycle A+B glitch
    arm = 1'b1; step(1); arm = 1'b0;
    wait_state(2, 20, "armed_again");
    set_sens(0, 1, 0); step(10);
    check("single_sensor", int'(state_o), 2);
    set_sens(1, 1, 0); step(1); set_sens(0, 0, 0);
    step(2);
    check("glitch", int'(state_o), QUAL_RUN == 3 ? 2 : 3);
    step(3);
    disarm = 1'b1; step(1); disarm = 1'b0;
    step(3);

    // disarm+arm together in entry at cnt=2
    arm = 1'b1; step(1); arm = 1'b0;
    wait_state(2, 20, "armed_for_entry");
    set_sens(1, 1, 0);
    wait_state(3, 20, "entry_reached");
    step(1);
    saved = int'(alarm_cnt);
    disarm = 1'b1; arm = 1'b1; step(1); disarm = 1'b0; arm = 1'b0;
    check("disarm_beats_arm", int'(state_o), 0);
    check("no_siren", int'(siren), 0);
    check("cnt_unchanged", int'(alarm_cnt), saved);
    set_sens(0, 0, 0);
    step(3);

    // randomized traffic against the model
    rbits = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 25) rbits = 3'($urandom_range(0, 7));
      set_sens(rbits[0], rbits[1], rbits[2]);
      arm    = ($urandom_range(0, 9) == 0);
      disarm = ($urandom_range(0, 59) == 0);
      step(1);
    end
    arm = 1'b0; disarm = 1'b1; step(1); disarm = 1'b0;
    set_sens(0, 0, 0);
    step(3);

    // saturation of alarm_cnt, then async reset mid-alarm
    arm = 1'b1; step(1); arm = 1'b0;
    wait_state(2, 20, "armed_for_sat");
    set_sens(1, 1, 1);
    n = 0;
    while (alarm_cnt !== 8'd255 && n < 7000) begin step(1); n++; end
    check("sat_reach", int'(alarm_cnt), 255);
    step(60);
    check("sat_hold", int'(alarm_cnt), 255);
    n = 0;
    while (!siren && n < 40) begin step(1); n++; end
    step(3);
    check("mid_alarm", int'(siren), 1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_rst_siren", int'(siren), 0);
    check("async_rst_state", int'(state_o), 0);
    check("async_rst_armed", int'(armed), 0);
    check("async_rst_cnt", int'(alarm_cnt), 0);
    set_sens(0, 0, 0);
    step(3);
    rst_n = 1'b1;
    step(5);
    check("post_rst_state", int'(state_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
